// File: rtl/mult4x4_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult4x4_seq_ctrl
//
// Sequencing controller for a 4x4 multiplier built around one shared 2x2
// multiplier. It loads the split operand registers, then walks the four
// hi/lo partial products. For each one it drives the operand-half selects,
// the partial-product shift amount and the accumulate strobe. The block
// contains no arithmetic.
//
// Parameters:
//   WAIT_CYCLES  idle cycles after each accumulate pulse (0..7), default 0
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      synchronous, active-high reset
//   start_i    start request, sampled in IDLE and DONE
//   abort_i    abort request (present only with MULT_SEQ_ABORT_EN)
//   ld_in_o    load enable for both split operand registers
//   acc_clr_o  clear product accumulator
//   acc_ld_o   accumulate shifted partial product
//   sel_a_o    operand-A half select (0 = bits [1:0], 1 = bits [3:2])
//   sel_b_o    operand-B half select, same encoding
//   shamt_o    partial-product left shift: 0, 2 or 4
//   busy_o     operation in progress
//   done_o     one-cycle completion pulse
//
// Optional feature macro: MULT_SEQ_ABORT_EN adds abort_i. When abort_i is
// high in LOAD, PP or WAIT, the controller returns to IDLE without
// producing a done pulse.
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start, all outputs low
// LOAD   | load operands, clear accumulator (1 cycle)
// PP     | accumulate partial product for the current step (1 cycle)
// WAIT   | latency gap after a PP step, selects held
// DONE   | completion pulse (1 cycle), start here goes straight to LOAD
//
// All outputs are registered. Their next values are decoded from the
// next state, so each output is valid in the same cycle as its state and
// there is no combinational path from start_i to any output.
// -----------------------------------------------------------------------------
module mult4x4_seq_ctrl #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
`ifdef MULT_SEQ_ABORT_EN
    input  logic       abort_i,
`endif
    output logic       ld_in_o,
    output logic       acc_clr_o,
    output logic       acc_ld_o,
    output logic       sel_a_o,
    output logic       sel_b_o,
    output logic [2:0] shamt_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PP,
        S_WAIT,
        S_DONE
    } state_t;

    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [2:0] WCNT_INIT = HAS_WAIT ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic [2:0] wcnt_q, wcnt_d;

    logic       ld_in_d, acc_clr_d, acc_ld_d, sel_a_d, sel_b_d, busy_d, done_d;
    logic [2:0] shamt_d;

    logic       abort_w;

`ifdef MULT_SEQ_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        wcnt_d  = wcnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                step_d  = 2'd0;
                wcnt_d  = 3'd0;
                state_d = S_PP;
            end
            S_PP: begin
                if (HAS_WAIT) begin
                    wcnt_d  = WCNT_INIT;
                    state_d = S_WAIT;
                end else if (step_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + 2'd1;
                    state_d = S_PP;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 3'd0) begin
                    if (step_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + 2'd1;
                        state_d = S_PP;
                    end
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            S_DONE: begin
                state_d = start_i ? S_LOAD : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort only applies while an operation is running; in DONE,
        // start keeps control.
        if (abort_w && (state_q == S_LOAD || state_q == S_PP || state_q == S_WAIT)) begin
            state_d = S_IDLE;
        end
    end

    // Output decode from the next state. WAIT reuses the PP step, so the
    // selects and the shift stay stable across the wait gap.
    always_comb begin
        ld_in_d   = 1'b0;
        acc_clr_d = 1'b0;
        acc_ld_d  = 1'b0;
        sel_a_d   = 1'b0;
        sel_b_d   = 1'b0;
        shamt_d   = 3'd0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_d)
            S_LOAD: begin
                ld_in_d   = 1'b1;
                acc_clr_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_PP, S_WAIT: begin
                acc_ld_d = (state_d == S_PP);
                busy_d   = 1'b1;
                sel_a_d  = step_d[1];
                sel_b_d  = step_d[0];
                // shamt = 2*(sel_a + sel_b): 0, 2, 2, 4
                shamt_d  = {step_d[1] & step_d[0], step_d[1] ^ step_d[0], 1'b0};
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            step_q    <= 2'd0;
            wcnt_q    <= 3'd0;
            ld_in_o   <= 1'b0;
            acc_clr_o <= 1'b0;
            acc_ld_o  <= 1'b0;
            sel_a_o   <= 1'b0;
            sel_b_o   <= 1'b0;
            shamt_o   <= 3'd0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            wcnt_q    <= wcnt_d;
            ld_in_o   <= ld_in_d;
            acc_clr_o <= acc_clr_d;
            acc_ld_o  <= acc_ld_d;
            sel_a_o   <= sel_a_d;
            sel_b_o   <= sel_b_d;
            shamt_o   <= shamt_d;
            busy_o    <= busy_d;
            done_o    <= done_d;
        end
    end

endmodule
